// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory controller.
package mem_pkg;

  // Controller FSM states.
  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of byte-offset bits in an address: log2(DATA_W/8).
  function automatic int byte_shift_f(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-index width: log2(DEPTH), never below 1 so vectors stay legal.
  function automatic int idx_w_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one combinational read port.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port; contents are cleared by the controller's init sweep, not by reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// Fixed-latency data memory controller: post-reset clear, legality checks,
// request capture and a LATENCY-cycle access pipeline with stall/done.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic              init_busy
);

  localparam int BYTE_SHIFT = byte_shift_f(DATA_W);
  localparam int IDX_W      = idx_w_f(DEPTH);
  localparam int FULL_W     = ADDR_W - BYTE_SHIFT;
  localparam int LAT_W      = $clog2(LATENCY) + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << BYTE_SHIFT) - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic              cap_wr_q, cap_wr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic [FULL_W-1:0] full_idx;
  logic [IDX_W-1:0]  in_idx;
  logic              req, illegal;

  // Request decode and legality; the index compare is one bit wider so a
  // DEPTH equal to the full index range never truncates to zero.
  always_comb begin
    full_idx = addr[ADDR_W-1:BYTE_SHIFT];
    in_idx   = full_idx[IDX_W-1:0];
    req      = mem_rd | mem_wr;
    illegal  = (mem_rd & mem_wr)
             | ((addr & ALIGN_MASK) != '0)
             | ({1'b0, full_idx} >= (FULL_W+1)'(DEPTH));
  end

  // Next-state, array port steering and outputs.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    cap_idx_d  = cap_idx_q;
    cap_data_d = cap_data_q;
    cap_wr_d   = cap_wr_q;
    rd_data_d  = rd_data_q;
    mem_we     = 1'b0;
    mem_waddr  = cap_idx_q;
    mem_wdata  = cap_data_q;
    mem_raddr  = cap_idx_q;
    stall      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    init_busy  = 1'b0;
    case (state_q)
      INIT: begin
        init_busy  = 1'b1;
        stall      = 1'b1;
        mem_we     = 1'b1;
        mem_waddr  = init_cnt_q;
        mem_wdata  = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d    = IDLE;
          init_cnt_d = '0;
        end
      end
      IDLE: begin
        if (req) begin
          if (illegal) begin
            err = 1'b1;
          end else begin
            stall      = 1'b1;
            cap_idx_d  = in_idx;
            cap_data_d = wr_data;
            cap_wr_d   = mem_wr;
            if (LATENCY > 1) begin
              state_d   = BUSY;
              lat_cnt_d = LAT_W'(LATENCY - 1);
            end else begin
              // Single-cycle latency: the access completes on the accepting
              // edge, so the array is driven from the live inputs.
              state_d   = DONE;
              mem_we    = mem_wr;
              mem_waddr = in_idx;
              mem_wdata = wr_data;
              mem_raddr = in_idx;
              if (mem_rd) rd_data_d = mem_rdata;
            end
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (lat_cnt_q == LAT_W'(1)) begin
          state_d = DONE;
          mem_we  = cap_wr_q;
          if (!cap_wr_q) rd_data_d = mem_rdata;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
    // A reset edge abandons any in-flight write.
    if (rst) mem_we = 1'b0;
  end

  // State, counters and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      lat_cnt_q  <= '0;
      cap_idx_q  <= '0;
      cap_data_q <= '0;
      cap_wr_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      cap_idx_q  <= cap_idx_d;
      cap_data_q <= cap_data_d;
      cap_wr_q   <= cap_wr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: LATENCY=2 instance driven from a vector table with
// a done-time scoreboard, plus a LATENCY=1 instance for back-to-back timing.
module tb_data_mem_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst, rst1;
  logic [15:0] addr, wr_data, addr1, wr_data1;
  logic        mem_rd, mem_wr, mem_rd1, mem_wr1;
  logic [15:0] rd_data, rd_data1;
  logic        stall, done, err, init_busy;
  logic        stall1, done1, err1, init_busy1;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .rd_data(rd_data), .stall(stall), .done(done), .err(err),
    .init_busy(init_busy)
  );

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .addr(addr1), .wr_data(wr_data1), .mem_rd(mem_rd1),
    .mem_wr(mem_wr1), .rd_data(rd_data1), .stall(stall1), .done(done1), .err(err1),
    .init_busy(init_busy1)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { logic [15:0] data; } sb_t;
  sb_t sb [$];

  logic [15:0] ref_mem [256];
  logic [15:0] last_rd;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    logic        exp_err;
    logic        corrupt;
  } vec_t;
  vec_t vt [16];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_init(output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 1000) begin
      n++;
      step();
    end
  endtask

  // Scoreboard: every done pulse must match one accepted access.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 32'(done), 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_rd_data", 32'(rd_data), 32'(e.data));
      end
    end
  end

  task automatic do_acc(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input logic corrupt);
    sb_t e;
    mem_rd = rd; mem_wr = wr; addr = a; wr_data = d;
    #1;
    chk("acc_stall_T", 32'(stall), 32'd1);
    chk("acc_err_T", 32'(err), 32'd0);
    chk("acc_done_T", 32'(done), 32'd0);
    if (wr) begin
      ref_mem[a[8:1]] = d;
    end else begin
      last_rd = ref_mem[a[8:1]];
    end
    e.data = last_rd;
    sb.push_back(e);
    for (int i = 1; i < LAT; i++) begin
      step();
      if (corrupt) begin
        addr = 16'h0020; wr_data = 16'hDEAD;
      end
      #1;
      chk("acc_stall_busy", 32'(stall), 32'd1);
      chk("acc_done_busy", 32'(done), 32'd0);
    end
    step();
    #1;
    chk("acc_done", 32'(done), 32'd1);
    chk("acc_stall_done", 32'(stall), 32'd0);
    step();
    mem_rd = 1'b0; mem_wr = 1'b0;
    #1;
    chk("acc_done_after", 32'(done), 32'd0);
    chk("acc_stall_after", 32'(stall), 32'd0);
  endtask

  task automatic do_bad(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d);
    mem_rd = rd; mem_wr = wr; addr = a; wr_data = d;
    #1;
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_stall", 32'(stall), 32'd0);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_rd_data", 32'(rd_data), 32'(last_rd));
    step();
    mem_rd = 1'b0; mem_wr = 1'b0;
    #1;
    chk("bad_err_clr", 32'(err), 32'd0);
    chk("bad_done_after", 32'(done), 32'd0);
    chk("bad_rd_data_after", 32'(rd_data), 32'(last_rd));
  endtask

  initial begin
    int n;
    vt[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 16'h0004, 16'hBEEF, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 16'h0004, 16'h1111, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 16'h01FE, 16'hA5A5, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 16'h01FE, 16'h0000, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 16'h0200, 16'hFFFF, 1'b1, 1'b0};
    vt[11] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b1, 16'h000C, 16'h5A5A, 1'b0, 1'b1};
    vt[13] = '{1'b1, 1'b0, 16'h000C, 16'h0000, 1'b0, 1'b0};
    vt[14] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0};
    vt[15] = '{1'b1, 1'b0, 16'h01FF, 16'h0000, 1'b1, 1'b0};

    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    last_rd = 16'h0000;
    rst = 1'b1; rst1 = 1'b1;
    addr = '0; wr_data = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    addr1 = '0; wr_data1 = '0; mem_rd1 = 1'b0; mem_wr1 = 1'b0;
    step(); step();
    rst = 1'b0; rst1 = 1'b0;
    #1;
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);

    // Requests during init are ignored; then restart the clear mid-way.
    mem_rd = 1'b1; addr = 16'h0003;
    for (int i = 0; i < 40; i++) step();
    #1;
    chk("init_err_masked", 32'(err), 32'd0);
    chk("init_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_rd = 1'b0; addr = '0;
    count_init(n);
    chk("init_cycles", 32'(n), 32'd256);
    chk("init_busy_low", 32'(init_busy), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_err", 32'(err), 32'd0);

    // Table of accesses against the LATENCY=2 instance.
    for (int i = 0; i < 16; i++) begin
      if (vt[i].exp_err) do_bad(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d);
      else               do_acc(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, vt[i].corrupt);
    end

    // Reset while a write is in BUSY: no done, init reruns, write is lost.
    mem_wr = 1'b1; addr = 16'h0008; wr_data = 16'h1234;
    #1;
    chk("rstbusy_stall_T", 32'(stall), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; mem_wr = 1'b0;
    #1;
    chk("rstbusy_init", 32'(init_busy), 32'd1);
    chk("rstbusy_rd_data", 32'(rd_data), 32'd0);
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    last_rd = 16'h0000;
    count_init(n);
    chk("rstbusy_init_cycles", 32'(n), 32'd256);
    do_acc(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0);
    do_acc(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
    chk("sb_pending", 32'(sb.size()), 32'd0);

    // LATENCY=1 instance: single-cycle stall, back-to-back reads every 2 cycles.
    chk("l1_idle", 32'(init_busy1), 32'd0);
    mem_wr1 = 1'b1; addr1 = 16'h0004; wr_data1 = 16'hC3C3;
    #1;
    chk("l1_wr_stall_T", 32'(stall1), 32'd1);
    chk("l1_wr_done_T", 32'(done1), 32'd0);
    step();
    #1;
    chk("l1_wr_done", 32'(done1), 32'd1);
    chk("l1_wr_stall", 32'(stall1), 32'd0);
    chk("l1_wr_rd_data", 32'(rd_data1), 32'd0);
    step();
    mem_wr1 = 1'b0; mem_rd1 = 1'b1; addr1 = 16'h0004;
    #1;
    chk("l1_rd_stall_T", 32'(stall1), 32'd1);
    step();
    addr1 = 16'h0006;
    #1;
    chk("l1_rd_done", 32'(done1), 32'd1);
    chk("l1_rd_stall", 32'(stall1), 32'd0);
    chk("l1_rd_data", 32'(rd_data1), 32'hC3C3);
    step();
    #1;
    chk("l1_rd2_stall_T", 32'(stall1), 32'd1);
    chk("l1_rd2_done_T", 32'(done1), 32'd0);
    chk("l1_rd_hold", 32'(rd_data1), 32'hC3C3);
    step();
    mem_rd1 = 1'b0;
    #1;
    chk("l1_rd2_done", 32'(done1), 32'd1);
    chk("l1_rd2_data", 32'(rd_data1), 32'd0);
    step();
    #1;
    chk("l1_rd2_after", 32'(done1), 32'd0);
    chk("l1_err", 32'(err1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
